// File: rtl/ahbl_apb_pkg.sv
// Shared types, AHB-Lite encodings and the transfer-size decoder for the
// AHB-Lite to APB4 bridge.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WCAP   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic       legal;
    logic [3:0] strb;
  } strb_dec_t;

  // Byte lanes touched by a transfer, plus whether the size/alignment pair
  // is one the APB side can carry.
  function automatic strb_dec_t decode_strb(input logic [2:0] size,
                                            input logic [1:0] addr);
    strb_dec_t d;
    // NOTE: every field gets a default before the case so no path leaves it
    // unassigned; in always_comb the same habit is what prevents latches.
    d.legal = 1'b1;
    d.strb  = 4'b0000;
    case (size)
      HSIZE_BYTE: d.strb = 4'b0001 << addr;
      HSIZE_HALF: begin
        d.legal = ~addr[0];
        d.strb  = addr[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        d.legal = (addr == 2'b00);
        d.strb  = 4'b1111;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ahbl_to_apb4_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per AHB beat,
// byte strobes, PSLVERR/timeout mapped onto the two-cycle AHB ERROR response.
module ahbl_to_apb4_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int PADDR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [2:0]             HBURST,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADYIN,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  output logic [PADDR_WIDTH-1:0] PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic [3:0]             PSTRB,
  input  logic [31:0]            PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e        state, state_nxt;
  logic [TW-1:0] to_cnt;
  strb_dec_t     dec;
  logic          ready_st;
  logic          accept;
  logic          timeout_hit;
  logic          unused_bits;

  assign unused_bits = ^{HBURST, HADDR[31:PADDR_WIDTH]};

  assign ready_st = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
  assign accept   = HSEL & HREADYIN & ready_st &
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign dec      = decode_strb(HSIZE, HADDR[1:0]);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Bus handshake and APB strobes are pure decodes of the state register,
  // so they follow reset on the same edge.
  assign HREADYOUT = ready_st;
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE   = (state == ST_ACCESS);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept)          state_nxt = ST_IDLE;
        else if (!dec.legal)  state_nxt = ST_ERR1;
        else if (HWRITE)      state_nxt = ST_WCAP;
        else                  state_nxt = ST_SETUP;
      end
      ST_WCAP:  state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY)           state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_nxt = ST_ERR1;
      end
      ST_ERR1:  state_nxt = ST_ERR2;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
      HRDATA <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= 4'b0000;
    end else begin
      state <= state_nxt;

      // Only accepted, legal beats touch the APB address side, so it never
      // changes while a SETUP/ACCESS is in flight.
      if (accept && dec.legal) begin
        PADDR  <= HADDR[PADDR_WIDTH-1:0];
        PWRITE <= HWRITE;
        PSTRB  <= HWRITE ? dec.strb : 4'b0000;
      end

      if (state == ST_WCAP)
        PWDATA <= HWDATA;

      if (state == ST_SETUP)
        to_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY)
        to_cnt <= to_cnt + TW'(1);

      if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE)
        HRDATA <= PRDATA;
    end
  end

endmodule

// File: tb/tb_ahbl_to_apb4_bridge.sv
// Directed bench for ahbl_to_apb4_bridge: table of single-beat transfers run
// back to back, plus reset, idle-response and reset-during-ACCESS sequences.
module tb_ahbl_to_apb4_bridge;
  import ahbl_apb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata;

  ahbl_to_apb4_bridge #(.PADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [2:0]  size;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;      // PREADY=0 cycles before completion
    logic        slverr;
    logic        exp_psel;
    logic [3:0]  exp_strb;
    int          exp_len;    // data-phase cycles incl. the HREADYOUT=1 cycle
    logic        exp_err;
    int          exp_access; // cycles with PSEL & PENABLE
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " hreadyout"}, 32'(HREADYOUT), 32'd1);
    check({tag, " hresp"},     32'(HRESP),     32'd0);
    check({tag, " hrdata"},    HRDATA,         32'd0);
    check({tag, " paddr"},     32'(PADDR),     32'd0);
    check({tag, " psel"},      32'(PSEL),      32'd0);
    check({tag, " penable"},   32'(PENABLE),   32'd0);
    check({tag, " pwrite"},    32'(PWRITE),    32'd0);
    check({tag, " pwdata"},    PWDATA,         32'd0);
    check({tag, " pstrb"},     32'(PSTRB),     32'd0);
  endtask

  // Issues one beat starting in the current cycle and returns in the cycle
  // where HREADYOUT goes high, so the next call pipelines into it.
  task automatic run_vec(input int idx, input vec_t v);
    int   cycles, n_access, first_psel, wait_left;
    logic prev_hresp, psel_seen;
    string tag;
    tag = $sformatf("vec%0d", idx);

    HSEL = 1'b1; HREADYIN = 1'b1; HTRANS = HTRANS_NONSEQ;
    HADDR = v.addr; HWRITE = v.write; HSIZE = v.size; HBURST = 3'b000;
    tick();
    HTRANS = HTRANS_IDLE; HWDATA = v.wdata;
    HADDR = 32'hFFFF_FFFF; HWRITE = ~v.write; HSIZE = 3'b111;

    cycles = 0; n_access = 0; first_psel = 0; wait_left = v.waits;
    prev_hresp = 1'b0; psel_seen = 1'b0;
    forever begin
      cycles++;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5A5A_5A5A;
      if (PSEL) begin
        if (!psel_seen) begin
          first_psel = cycles;
          check({tag, " setup penable"}, 32'(PENABLE), 32'd0);
        end
        psel_seen = 1'b1;
        check({tag, " paddr"},  32'(PADDR),  32'(v.addr[15:0]));
        check({tag, " pstrb"},  32'(PSTRB),  32'(v.exp_strb));
        check({tag, " pwrite"}, 32'(PWRITE), 32'(v.write));
        if (v.write) check({tag, " pwdata"}, PWDATA, v.wdata);
        if (PENABLE) begin
          n_access++;
          if (wait_left > 0) wait_left--;
          else begin
            PREADY = 1'b1; PSLVERR = v.slverr; PRDATA = v.prdata;
          end
        end
      end
      if (HREADYOUT || cycles >= 40) break;
      prev_hresp = HRESP;
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    check({tag, " len"},       32'(cycles),    32'(v.exp_len));
    check({tag, " hresp"},     32'(HRESP),     32'(v.exp_err));
    if (v.exp_err) check({tag, " err1 hresp"}, 32'(prev_hresp), 32'd1);
    check({tag, " psel seen"}, 32'(psel_seen), 32'(v.exp_psel));
    check({tag, " access"},    32'(n_access),  32'(v.exp_access));
    if (v.exp_psel) check({tag, " first psel"}, 32'(first_psel), v.write ? 32'd2 : 32'd1);
    if (!v.write && v.exp_psel && !v.exp_err) last_rdata = v.prdata;
    check({tag, " hrdata"},    HRDATA,         last_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  tv;
    int    n;

    //               size  addr          wr  wdata         prdata        wt   err psel strb    len err acc
    vecs[0]  = '{3'd2, 32'h0000_0104, 1'b0, 32'h0,        32'hDEADBEEF, 0,   1'b0, 1'b1, 4'b0000, 3,  1'b0, 1};
    vecs[1]  = '{3'd0, 32'h0000_0203, 1'b1, 32'hAA000000, 32'h0,        0,   1'b0, 1'b1, 4'b1000, 4,  1'b0, 1};
    vecs[2]  = '{3'd1, 32'h0000_0202, 1'b1, 32'h12345678, 32'h0,        0,   1'b0, 1'b1, 4'b1100, 4,  1'b0, 1};
    vecs[3]  = '{3'd1, 32'h1000_0010, 1'b0, 32'h0,        32'h0BADF00D, 1,   1'b0, 1'b1, 4'b0000, 4,  1'b0, 2};
    vecs[4]  = '{3'd0, 32'h0000_0001, 1'b1, 32'h0000BB00, 32'h0,        0,   1'b0, 1'b1, 4'b0010, 4,  1'b0, 1};
    vecs[5]  = '{3'd2, 32'h0000_0008, 1'b1, 32'hCAFEF00D, 32'h0,        0,   1'b1, 1'b1, 4'b1111, 5,  1'b1, 1};
    vecs[6]  = '{3'd1, 32'h0000_0001, 1'b0, 32'h0,        32'h0,        0,   1'b0, 1'b0, 4'b0000, 2,  1'b1, 0};
    vecs[7]  = '{3'd3, 32'h0000_0000, 1'b1, 32'h1,        32'h0,        0,   1'b0, 1'b0, 4'b0000, 2,  1'b1, 0};
    vecs[8]  = '{3'd2, 32'h0000_0102, 1'b0, 32'h0,        32'h0,        0,   1'b0, 1'b0, 4'b0000, 2,  1'b1, 0};
    vecs[9]  = '{3'd2, 32'h0000_0300, 1'b0, 32'h0,        32'hFFFFFFFF, 0,   1'b1, 1'b1, 4'b0000, 4,  1'b1, 1};
    vecs[10] = '{3'd2, 32'h0000_0020, 1'b0, 32'h0,        32'h11223344, 2,   1'b0, 1'b1, 4'b0000, 5,  1'b0, 3};
    vecs[11] = '{3'd2, 32'h0000_0024, 1'b1, 32'h55667788, 32'h0,        2,   1'b0, 1'b1, 4'b1111, 6,  1'b0, 3};
    vecs[12] = '{3'd2, 32'h0000_0030, 1'b0, 32'h0,        32'h99999999, 100, 1'b0, 1'b1, 4'b0000, 11, 1'b1, 8};

    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HSIZE = '0; HBURST = '0; HWDATA = '0; HREADYIN = 1'b1;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    last_rdata = '0;
    tick(); tick();
    check_reset("reset");
    HRESET = 1'b0;

    // IDLE/BUSY beats and deselected NONSEQ get a zero-wait OKAY.
    HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h40;
    tick();
    check("busy hreadyout", 32'(HREADYOUT), 32'd1);
    check("busy psel",      32'(PSEL),      32'd0);
    HSEL = 1'b0; HTRANS = HTRANS_NONSEQ;
    tick();
    check("nosel hreadyout", 32'(HREADYOUT), 32'd1);
    check("nosel hresp",     32'(HRESP),     32'd0);
    check("nosel psel",      32'(PSEL),      32'd0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
    HTRANS = HTRANS_IDLE;
    tick();
    check("tail idle hreadyout", 32'(HREADYOUT), 32'd1);
    check("tail idle hresp",     32'(HRESP),     32'd0);

    // Reset while an access is hanging in ACCESS.
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0044; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    tick();
    HTRANS = HTRANS_IDLE; PREADY = 1'b0;
    n = 0;
    while (!(PSEL && PENABLE) && n < 10) begin tick(); n++; end
    check("rst reach access", 32'(PSEL & PENABLE), 32'd1);
    tick();
    HRESET = 1'b1;
    tick();
    check_reset("rst in access");
    HRESET = 1'b0;
    last_rdata = '0;
    tick();

    // Seven waits: PREADY arrives on the last ACCESS cycle before expiry.
    tv = '{3'd2, 32'h0000_0050, 1'b0, 32'h0, 32'h7777_0001, 7, 1'b0, 1'b1, 4'b0000, 10, 1'b0, 8};
    run_vec(13, tv);
    HTRANS = HTRANS_IDLE;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
